// File: rtl/pipelined_adder_pkg.sv
// Shared constants and types for the pipelined adder.
// Default geometry plus the result flag bundle.
package pipelined_adder_pkg;

    localparam int unsigned DefaultWidth = 8;
    localparam int unsigned DefaultSlice = 4;

    typedef struct packed {
        logic carry;
        logic overflow;
        logic zero;
        logic negative;
    } flags_t;

endpackage

// File: rtl/pipelined_adder_if.sv
// Operand/result handshake bundle for pipelined_adder.
// The master drives operands and consumes results; the slave is the adder.
interface pipelined_adder_if
    import pipelined_adder_pkg::*;
#(
    parameter int unsigned WIDTH = DefaultWidth
);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             carry_in;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             carry_out;
    logic             overflow;
    logic             zero;
    logic             negative;

    modport master (
        output in_valid, a, b, carry_in, sub, out_ready,
        input  in_ready, out_valid, sum, carry_out, overflow, zero, negative
    );

    modport slave (
        input  in_valid, a, b, carry_in, sub, out_ready,
        output in_ready, out_valid, sum, carry_out, overflow, zero, negative
    );

endinterface

// File: rtl/adder_slice.sv
// Combinational SLICE-bit adder with carry in and carry out.
module adder_slice #(
    parameter int unsigned SLICE = 4
) (
    input  logic [SLICE-1:0] a,
    input  logic [SLICE-1:0] b,
    input  logic             cin,
    output logic [SLICE-1:0] sum,
    output logic             cout
);

    assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{SLICE{1'b0}}, cin};

endmodule

// File: rtl/pipelined_adder.sv
// Carry-pipelined adder/subtractor: SLICE bits resolved per stage, WIDTH/SLICE stages,
// valid/ready handshake with a global stall when the output is not taken.
module pipelined_adder
    import pipelined_adder_pkg::*;
#(
    parameter int unsigned WIDTH = DefaultWidth,
    parameter int unsigned SLICE = DefaultSlice
) (
    input logic              clk,
    input logic              rst_n,
    pipelined_adder_if.slave bus
);

    localparam int unsigned STAGES = WIDTH / SLICE;
    localparam int unsigned LAST   = STAGES - 1;

    if (WIDTH % SLICE != 0) begin : g_bad_param
        $error("WIDTH must be an integer multiple of SLICE");
    end

    logic [STAGES-1:0]            v_in, v_q, c_in, c_q, c_slice;
    logic [STAGES-1:0][WIDTH-1:0] a_in, b_in, s_in, s_next, a_q, b_q, s_q;
    logic [STAGES-1:0][SLICE-1:0] s_slice;
    logic                         stall;
    flags_t                       flags;

    assign stall = v_q[LAST] & ~bus.out_ready;

    // Stage k consumes the registers of stage k-1; stage 0 consumes the bus directly.
    always_comb begin
        a_in[0] = bus.a;
        b_in[0] = bus.b ^ {WIDTH{bus.sub}};
        s_in[0] = '0;
        c_in[0] = bus.carry_in;
        v_in[0] = bus.in_valid;
        for (int unsigned k = 1; k < STAGES; k++) begin
            a_in[k] = a_q[k-1];
            b_in[k] = b_q[k-1];
            s_in[k] = s_q[k-1];
            c_in[k] = c_q[k-1];
            v_in[k] = v_q[k-1];
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_slice
        adder_slice #(
            .SLICE(SLICE)
        ) u_slice (
            .a   (a_in[k][k*SLICE +: SLICE]),
            .b   (b_in[k][k*SLICE +: SLICE]),
            .cin (c_in[k]),
            .sum (s_slice[k]),
            .cout(c_slice[k])
        );
    end

    always_comb begin
        for (int unsigned k = 0; k < STAGES; k++) begin
            s_next[k]                    = s_in[k];
            s_next[k][k*SLICE +: SLICE]  = s_slice[k];
        end
    end

    // Data only loads behind a valid token, so bubbles leave the payload untouched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_q <= '0;
            c_q <= '0;
            a_q <= '0;
            b_q <= '0;
            s_q <= '0;
        end else if (!stall) begin
            v_q <= v_in;
            for (int unsigned k = 0; k < STAGES; k++) begin
                if (v_in[k]) begin
                    a_q[k] <= a_in[k];
                    b_q[k] <= b_in[k];
                    s_q[k] <= s_next[k];
                    c_q[k] <= c_slice[k];
                end
            end
        end
    end

    // Zero is qualified by valid so the cleared result register does not report zero.
    always_comb begin
        flags.carry    = c_q[LAST];
        flags.overflow = (a_q[LAST][WIDTH-1] == b_q[LAST][WIDTH-1]) &&
                         (s_q[LAST][WIDTH-1] != a_q[LAST][WIDTH-1]);
        flags.zero     = v_q[LAST] && (s_q[LAST] == '0);
        flags.negative = s_q[LAST][WIDTH-1];
    end

    // Consumed operand slices stay in the stage registers but are never read again.
    logic unused_operand_bits;
    assign unused_operand_bits = ^{a_in, b_in, a_q, b_q};

    assign bus.in_ready  = ~stall;
    assign bus.out_valid = v_q[LAST];
    assign bus.sum       = s_q[LAST];
    assign bus.carry_out = flags.carry;
    assign bus.overflow  = flags.overflow;
    assign bus.zero      = flags.zero;
    assign bus.negative  = flags.negative;

endmodule

// File: tb/tb_pipelined_adder.sv
// Randomized bench for pipelined_adder with an arithmetic reference model,
// plus directed literal cases for arithmetic, stall, throughput and reset.
module tb_pipelined_adder;

    localparam int unsigned W      = 8;
    localparam int unsigned S      = 4;
    localparam int unsigned STAGES = W / S;
    localparam int          SMAX   = (1 << (W - 1)) - 1;
    localparam int          SMIN   = -SMAX - 1;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pipelined_adder_if #(.WIDTH(W)) bus ();

    pipelined_adder #(
        .WIDTH(W),
        .SLICE(S)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    typedef struct {
        logic [W-1:0] s;
        logic         c;
        logic         ov;
        logic         z;
        logic         n;
        int           adv_at;
    } exp_t;

    exp_t q[$];
    exp_t nxt;
    int   total    = 0;
    int   bad      = 0;
    int   adv      = 0;
    int   run_len  = 0;
    int   last_run = 0;
    bit   front_seen = 1'b0;

    function automatic void chk(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Result from plain integer arithmetic; overflow from the signed range.
    function automatic exp_t model(input logic [W-1:0] a_v, input logic [W-1:0] b_v,
                                   input logic ci, input logic sb);
        exp_t         r;
        logic [W-1:0] be;
        int           u;
        int           sgn;
        be       = sb ? ~b_v : b_v;
        u        = int'(a_v) + int'(be) + int'(ci);
        sgn      = int'($signed(a_v)) + int'($signed(be)) + int'(ci);
        r.s      = u[W-1:0];
        r.c      = u[W];
        r.ov     = (sgn > SMAX) || (sgn < SMIN);
        r.z      = (u[W-1:0] == '0);
        r.n      = u[W-1];
        r.adv_at = 0;
        return r;
    endfunction

    // Scoreboard: every visible result is checked against the oldest accepted operand set.
    always @(negedge clk) begin
        bit stall;
        if (!rst_n) begin
            q.delete();
            front_seen = 1'b0;
            run_len    = 0;
        end else begin
            stall = bus.out_valid && !bus.out_ready;
            chk("in_ready", bus.in_ready, !stall);
            if (bus.out_valid) begin
                run_len++;
                chk("pending_for_output", q.size() > 0, 1);
                if (q.size() > 0) begin
                    if (!front_seen) begin
                        chk("latency_advances", adv - q[0].adv_at, STAGES);
                        front_seen = 1'b1;
                    end
                    chk("sum", bus.sum, q[0].s);
                    chk("carry_out", bus.carry_out, q[0].c);
                    chk("overflow", bus.overflow, q[0].ov);
                    chk("zero", bus.zero, q[0].z);
                    chk("negative", bus.negative, q[0].n);
                end
            end else begin
                if (run_len > 0) last_run = run_len;
                run_len = 0;
            end
            if (bus.out_valid && bus.out_ready && q.size() > 0) begin
                void'(q.pop_front());
                front_seen = 1'b0;
            end
            if (bus.in_valid && bus.in_ready) begin
                nxt        = model(bus.a, bus.b, bus.carry_in, bus.sub);
                nxt.adv_at = adv;
                q.push_back(nxt);
            end
            if (!stall) adv++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [W-1:0] a_v, input logic [W-1:0] b_v,
                        input logic ci, input logic sb);
        int n;
        n            = 0;
        bus.in_valid = 1'b1;
        bus.a        = a_v;
        bus.b        = b_v;
        bus.carry_in = ci;
        bus.sub      = sb;
        @(negedge clk);
        while (!bus.in_ready && n < 50) begin
            n++;
            @(negedge clk);
        end
        chk("send_accepted", bus.in_ready, 1);
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic directed(input string nm, input logic [W-1:0] a_v, input logic [W-1:0] b_v,
                            input logic ci, input logic sb, input logic [W-1:0] e_s,
                            input logic e_c, input logic e_ov, input logic e_z, input logic e_n);
        send(a_v, b_v, ci, sb);
        repeat (STAGES - 1) @(posedge clk);
        @(negedge clk);
        chk({nm, "_valid"}, bus.out_valid, 1);
        chk({nm, "_sum"}, bus.sum, e_s);
        chk({nm, "_carry"}, bus.carry_out, e_c);
        chk({nm, "_ovf"}, bus.overflow, e_ov);
        chk({nm, "_zero"}, bus.zero, e_z);
        chk({nm, "_neg"}, bus.negative, e_n);
        tick();
    endtask

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 5))
            0:       return '0;
            1:       return {W{1'b1}};
            2:       return {1'b0, {(W-1){1'b1}}};
            3:       return {1'b1, {(W-1){1'b0}}};
            default: return W'($urandom);
        endcase
    endfunction

    task automatic check_reset_outputs(input string nm);
        chk({nm, "_out_valid"}, bus.out_valid, 0);
        chk({nm, "_sum"}, bus.sum, 0);
        chk({nm, "_carry"}, bus.carry_out, 0);
        chk({nm, "_ovf"}, bus.overflow, 0);
        chk({nm, "_zero"}, bus.zero, 0);
        chk({nm, "_neg"}, bus.negative, 0);
        chk({nm, "_in_ready"}, bus.in_ready, 1);
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.carry_in  = 1'b0;
        bus.sub       = 1'b0;
        bus.out_ready = 1'b1;
        #3;
        check_reset_outputs("reset");
        #20 rst_n = 1'b1;
        tick();

        directed("add_0f_01", 8'h0F, 8'h01, 1'b0, 1'b0, 8'h10, 1'b0, 1'b0, 1'b0, 1'b0);
        directed("add_7f_01", 8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1, 1'b0, 1'b1);
        directed("add_ff_01", 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0);
        directed("sub_05_07", 8'h05, 8'h07, 1'b1, 1'b1, 8'hFE, 1'b0, 1'b0, 1'b0, 1'b1);
        directed("sub_80_01", 8'h80, 8'h01, 1'b1, 1'b1, 8'h7F, 1'b1, 1'b1, 1'b0, 1'b0);

        // Ten operands back to back must come out as one unbroken run of ten.
        for (int i = 0; i < 10; i++) send(pick(), pick(), 1'($urandom), 1'($urandom));
        repeat (STAGES + 2) tick();
        chk("b2b_run", last_run, 10);

        // Fill the pipe with the output blocked, hold three cycles, then release.
        bus.out_ready = 1'b0;
        send(8'h12, 8'h34, 1'b0, 1'b0);
        send(8'hF0, 8'h0F, 1'b1, 1'b0);
        bus.in_valid = 1'b1;
        bus.a        = 8'hA5;
        bus.b        = 8'h5A;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stall_in_ready", bus.in_ready, 0);
            chk("stall_out_valid", bus.out_valid, 1);
            tick();
        end
        bus.out_ready = 1'b1;
        send(8'hA5, 8'h5A, 1'b0, 1'b1);
        repeat (STAGES + 4) tick();
        chk("stall_drain", q.size(), 0);

        // Two operations in flight, then an asynchronous reset mid-cycle.
        send(8'h7F, 8'h01, 1'b0, 1'b0);
        send(8'hFF, 8'h01, 1'b0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        check_reset_outputs("midreset");
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        for (int i = 0; i < STAGES + 3; i++) begin
            @(negedge clk);
            chk("post_reset_out_valid", bus.out_valid, 0);
            tick();
        end

        for (int i = 0; i < 400; i++) begin
            bus.in_valid  = ($urandom_range(0, 9) < 7);
            bus.a         = pick();
            bus.b         = pick();
            bus.carry_in  = 1'($urandom);
            bus.sub       = 1'($urandom);
            bus.out_ready = ($urandom_range(0, 9) < 7);
            tick();
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 30 && q.size() > 0; i++) tick();
        chk("random_drain", q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/pipelined_adder.md
PIPELINED_ADDER -- requirements
Module: pipelined_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 8: operand/result width in bits.
REQ-002 SHALL have parameter SLICE, default 4: bits added per pipeline stage; WIDTH SHALL be an integer multiple of SLICE; STAGES = WIDTH/SLICE.
REQ-003 SHALL have port clk  input  1  single clock; all state rising-edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port in_valid  input  1  operand set present.
REQ-006 SHALL have port in_ready  output  1  block accepts operands this cycle.
REQ-007 SHALL have port a  input  WIDTH  operand A.
REQ-008 SHALL have port b  input  WIDTH  operand B.
REQ-009 SHALL have port carry_in  input  1  carry into bit 0.
REQ-010 SHALL have port sub  input  1  1 = subtract mode, B inverted.
REQ-011 SHALL have port out_valid  output  1  result present.
REQ-012 SHALL have port out_ready  input  1  downstream accepts result.
REQ-013 SHALL have port sum  output  WIDTH  result.
REQ-014 SHALL have port carry_out  output  1  carry out of bit WIDTH-1.
REQ-015 SHALL have port overflow  output  1  signed overflow.
REQ-016 SHALL have ports zero, negative  output  1 each  sum==0; sum[WIDTH-1].

Function
REQ-017 SHALL compute {carry_out,sum} = a + (b XOR {WIDTH{sub}}) + carry_in, full WIDTH+1-bit precision.
REQ-018 SHALL set overflow = (a[MSB] == b_eff[MSB]) AND (sum[MSB] != a[MSB]), b_eff = b XOR {WIDTH{sub}}.
REQ-019 SHALL add SLICE bits per stage: stage k adds slice k using carry registered from stage k-1; higher slices of a, b_eff travel unmodified in pipeline registers; lower result slices travel forward.
REQ-020 SHALL accept a transfer when in_valid AND in_ready; SHALL present its result exactly STAGES cycles later absent stalls.
REQ-021 SHALL define stall = out_valid AND NOT out_ready; while stalled, every stage register SHALL hold and in_ready SHALL be 0.
REQ-022 SHALL drive in_ready = NOT stall (combinational); in_ready SHALL NOT depend on in_valid.
REQ-023 SHALL advance each stage valid bit every non-stall cycle; bubbles (in_valid=0) SHALL propagate as valid=0 and not be collapsed.
REQ-024 SHALL hold sum, carry_out, flags stable while out_valid=1 and out_ready=0.
REQ-025 SHALL sustain throughput of one result per cycle when out_ready is held 1.
REQ-026 SHALL accept a new operand in the same cycle the final result is consumed (out_ready=1 clears stall).
REQ-027 SHALL ignore a, b, carry_in, sub when the transfer does not occur.
REQ-028 SHALL behave as a single registered stage (latency 1) when SLICE = WIDTH.

Reset
REQ-029 SHALL on rst_n=0 clear all stage valid bits and drive out_valid=0, sum=0, carry_out=0, overflow=0, zero=0, negative=0, immediately (asynchronously).
REQ-030 SHALL discard in-flight operations on mid-operation reset; none SHALL appear after release.
REQ-031 SHALL have in_ready=1 during and after reset.

Structure
REQ-032 SHALL place default WIDTH/SLICE constants and the flag-bundle typedef (carry, overflow, zero, negative) in the shared CPU package.
REQ-033 SHALL instantiate one sub-module, adder_slice (SLICE-bit combinational add with carry in/out), once per stage via generate.

Verification (WIDTH=8, SLICE=4, latency 2)
REQ-034 SHALL check a=0x0F, b=0x01, carry_in=0, sub=0 -> after 2 cycles sum=0x10, carry_out=0, overflow=0, zero=0.
REQ-035 SHALL check a=0x7F, b=0x01 add -> sum=0x80, overflow=1, negative=1; a=0xFF, b=0x01 -> sum=0x00, carry_out=1, zero=1.
REQ-036 SHALL check a=0x05, b=0x07, sub=1, carry_in=1 -> sum=0xFE, carry_out=0, negative=1.
REQ-037 SHALL check back-to-back 10 operands with out_ready=1 -> 10 consecutive out_valid cycles, results in order.
REQ-038 SHALL check out_ready=0 for 3 cycles with full pipeline -> in_ready=0, outputs frozen, no loss or duplication after release.
REQ-039 SHALL check rst_n pulsed low with 2 operations in flight -> out_valid=0 immediately, no stale result afterward.
